// File: rtl/xpb_table_gen.sv
// -----------------------------------------------------------------------------
// xpb_table_gen
//
// Runtime-programmable XPB table for the modular-squaring reduction path.
// After a start pulse the block fills an internal table with
// entry[k] = (k * base) mod modulus, one entry per clock. It then serves
// NUM_RD independent read channels. Each channel has a one-cycle registered
// read.
//
// The accumulator walks 0, B, 2B, ... modulo M. One conditional subtract per
// step is enough because B < M, so acc + B < 2M.
//
// Parameters:
//   SEL_BITS  select width; the table holds 2**SEL_BITS entries
//   DATA_W    entry width in bits
//   NUM_RD    number of read channels
//
// Ports:
//   clk       single clock; all logic is rising-edge
//   reset     synchronous, active-high
//   start     one-cycle request to (re)generate the table; accepted in IDLE only
//   base      multiplicand B, sampled at an accepted start (must be < modulus)
//   modulus   modulus M, sampled at an accepted start (must be >= 2)
//   busy      generation in progress
//   ready     table complete and readable
//   rd_req    per-channel read request
//   rd_sel    per-channel index; channel i uses bits [i*SEL_BITS +: SEL_BITS]
//   rd_data   per-channel registered entry; holds its value when not reading
//   rd_valid  per-channel data-valid, one cycle after an accepted request
//
// Optional feature (macro XPB_EXT_LOAD_EN):
//   wr_en     external write strobe; honoured in IDLE only
//   wr_addr   external write index
//   wr_data   external write data
//   An external write also sets ready. Software can therefore preload a
//   constant table without running the generator. An accepted start in the
//   same cycle takes precedence, and the write is dropped.
// -----------------------------------------------------------------------------
module xpb_table_gen #(
    parameter int SEL_BITS = 5,
    parameter int DATA_W   = 1024,
    parameter int NUM_RD   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_W-1:0]          base,
    input  logic [DATA_W-1:0]          modulus,
`ifdef XPB_EXT_LOAD_EN
    input  logic                       wr_en,
    input  logic [SEL_BITS-1:0]        wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
`endif
    output logic                       busy,
    output logic                       ready,
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [NUM_RD*SEL_BITS-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid
);

    localparam int DEPTH = 1 << SEL_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    state_t              state_q, state_d;

    // Control state (reset)
    logic [SEL_BITS-1:0] k_q, k_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;

    // Operand and accumulator registers. These are loaded at start and are
    // meaningless before that, so reset does not touch them.
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [DATA_W-1:0]   acc_q, acc_d;

    // Single table write port, shared by the generator and the external loader
    logic                tbl_we;
    logic [SEL_BITS-1:0] tbl_waddr;
    logic [DATA_W-1:0]   tbl_wdata;

    logic [DATA_W-1:0]   tbl [DEPTH];

    // Modular step: the sum is one bit wider so that acc + B cannot overflow
    // before it is compared with M.
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   acc_next;

    assign sum      = {1'b0, acc_q} + {1'b0, b_q};
    assign diff     = sum - {1'b0, m_q};
    assign acc_next = (sum >= {1'b0, m_q}) ? diff[DATA_W-1:0] : sum[DATA_W-1:0];

    assign busy  = busy_q;
    assign ready = ready_q;

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        b_d       = b_q;
        m_d       = m_q;
        acc_d     = acc_q;
        tbl_we    = 1'b0;
        tbl_waddr = k_q;
        tbl_wdata = acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d     = base;
                    m_d     = modulus;
                    acc_d   = '0;
                    k_d     = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = GEN;
                end
`ifdef XPB_EXT_LOAD_EN
                else if (wr_en) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = wr_addr;
                    tbl_wdata = wr_data;
                    ready_d   = 1'b1;
                end
`endif
            end

            GEN: begin
                // start (and wr_en) are deliberately not looked at here.
                // A request during generation is dropped, not queued.
                tbl_we    = 1'b1;
                tbl_waddr = k_q;
                tbl_wdata = acc_q;
                acc_d     = acc_next;
                k_d       = k_q + SEL_BITS'(1);
                if (k_q == SEL_BITS'(DEPTH - 1)) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge, whatever the block order.
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Operand/accumulator registers (no reset needed, see above)
    always_ff @(posedge clk) begin
        b_q   <= b_d;
        m_q   <= m_d;
        acc_q <= acc_d;
    end

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    // NOTE: the table has no reset. Clearing it would prevent mapping to RAM,
    // and ready=0 already hides stale or partial contents from every reader.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl[tbl_waddr] <= tbl_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read channels: independent, one-cycle registered, gated by ready
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_valid[i] <= rd_req[i] && ready_q;
                if (rd_req[i] && ready_q) begin
                    rd_data[i*DATA_W +: DATA_W] <= tbl[rd_sel[i*SEL_BITS +: SEL_BITS]];
                end
            end
        end
    end

endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Runtime-programmable XPB (precomputed multiple-of-base mod modulus) table for the modular-squaring reduction path.
- Replaces fixed constant lookup tables: the block computes entry k = (k·base) mod modulus after a `start` pulse, one entry per cycle, into internal storage.
- It then serves NUM_RD independent registered read channels.
- The squarer instantiates one per reduction segment. Reloading base/modulus changes the modulus without resynthesis.

## Interface
Parameters:
- SEL_BITS, 5, select width; table depth = 2^SEL_BITS entries
- DATA_W, 1024, entry width in bits
- NUM_RD, 2, number of read channels

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to (re)generate the table
- base  in  DATA_W  multiplicand; sampled at accepted start; must be < modulus
- modulus  in  DATA_W  modulus M; sampled at accepted start; must be ≥ 2
- busy  out  1  generation in progress
- ready  out  1  table complete and valid for reads
- rd_req  in  NUM_RD  per-channel read request
- rd_sel  in  NUM_RD·SEL_BITS  per-channel index; channel i = bits [i·SEL_BITS +: SEL_BITS]
- rd_data  out  NUM_RD·DATA_W  per-channel registered entry
- rd_valid  out  NUM_RD  per-channel data-valid

## Operation
The FSM has two states: IDLE and GEN.

IDLE:
- `start`=1 is accepted.
- On acceptance, the block latches base→B and modulus→M, clears the accumulator to 0, sets k=0, clears ready, sets busy, and moves to GEN.

GEN, each cycle:
- Write acc to entry k.
- Compute s = acc + B at DATA_W+1 bits.
- Update acc ← (s ≥ M) ? s − M : s, using a single conditional subtract. This is valid because B < M.
- Increment k.
- When k = 2^SEL_BITS−1 has been written: clear busy, set ready, return to IDLE.

Start handling:
- `start` during GEN is ignored. It neither restarts nor queues.
- `start` in IDLE while ready=1 regenerates the table. ready drops the cycle after acceptance.

Reads, per channel and independent:
- If rd_req[i] && ready at edge t, then at edge t+1 rd_data[i] = entry[rd_sel[i]] and rd_valid[i]=1.
- Otherwise rd_valid[i]=0 and rd_data[i] holds its previous value.
- Multiple channels may read the same index in the same cycle; all receive identical data.

Behaviour is undefined if base ≥ modulus or modulus < 2. No checking is done.

## Timing
- Reset values: busy=0, ready=0, rd_valid=0, rd_data=0. The FSM is in IDLE with k=0.
- Table storage is not cleared by reset. ready=0 gates all reads.
- Generation: start accepted at edge t0. busy=1 from t0+1 through t0+2^SEL_BITS. Entry k is written at edge t0+1+k.
- Completion: ready=1 and busy=0 at t0+2^SEL_BITS+1, i.e. 33 cycles for SEL_BITS=5.
- Read latency is 1 cycle. A request in the same cycle ready first rises is served.
- Reset asserted during GEN aborts generation: next cycle busy=0, ready=0, IDLE. Partial contents remain but are unreadable until a full regeneration.
- reset has priority over start in the same cycle.

## Configuration
Macro `XPB_EXT_LOAD_EN`:
- Defined: adds ports wr_en (in, 1), wr_addr (in, SEL_BITS) and wr_data (in, DATA_W).
  - A write in IDLE stores wr_data to entry wr_addr at the next edge.
  - After a write, ready is set at the next edge, so software that preloads a constant table asserts ready by writing.
  - wr_en during GEN is ignored.
  - In the same cycle as an accepted start, start wins and the write is dropped.
- Undefined: the ports and write logic are absent. The table is populated only by the generator.

## Test plan
Bench uses DATA_W=16, SEL_BITS=5, NUM_RD=2.
- Reset: after reset, busy=0, ready=0, rd_valid=0, rd_data=0. rd_req=2'b11 while not ready → rd_valid stays 0.
- Generate: M=0xFFF1, base=0x1234, start at t0 → ready at t0+33. Then sel 0→0x0000, sel 2→0x2468, sel 31→0x346A, each with rd_valid 1 cycle after the request.
- Wrap: M=7, base=5 → entries 0..7 = 0,5,3,1,6,4,2,0. Both channels read sel 6 in the same cycle → both return 0x0002.
- Ignored start: start pulses at t0+10 during GEN → completion still at t0+33 and contents are those of the first request.
- Reset mid-run: reset at t0+12 → busy=0 and ready=0 next cycle. A fresh start then yields a correct full table 33 cycles later.
- `XPB_EXT_LOAD_EN`: wr_en with addr 3 and data 0xBEEF in IDLE → ready=1 next edge. A read of sel 3 one cycle later returns 0xBEEF.
